// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: ALU operation codes, forwarding
// selector codes, register-update kinds and the stage-control bundle.
package id_ex_stage_pkg;

  localparam int DW_DEF  = 32;
  localparam int RW_DEF  = 5;
  localparam int OPW_DEF = 5;

  // ALUOp_NOP is the code a bubble carries, so the ALU sees a harmless op.
  localparam logic [4:0] ALUOp_NOP  = 5'd0;
  localparam logic [4:0] ALUOp_ADDU = 5'd1;
  localparam logic [4:0] ALUOp_SUBU = 5'd2;
  localparam logic [4:0] ALUOp_OR   = 5'd3;
  localparam logic [4:0] ALUOp_ADD  = 5'd4;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    UPD_CAPTURE = 2'b00,
    UPD_HOLD    = 2'b01,
    UPD_BUBBLE  = 2'b10
  } upd_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(4'b0000);

  // Flush beats stall, and stall beats the load-use bubble so a held
  // hazard is re-evaluated once the stall lifts.
  function automatic upd_e upd_select(input logic flush, input logic stall,
                                      input logic hazard);
    upd_e sel;
    if (flush) begin
      sel = UPD_BUBBLE;
    end else if (stall) begin
      sel = UPD_HOLD;
    end else if (hazard) begin
      sel = UPD_BUBBLE;
    end else begin
      sel = UPD_CAPTURE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one source register: picks EX/MEM, then MEM/WB,
// then the registered register-file value. Register 0 is never forwarded.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] src_idx_i,
  input  logic [DW-1:0] reg_data_i,
  input  logic          exmem_regwrite_i,
  input  logic [RW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_regwrite_i,
  input  logic [RW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_data_i,
  output logic [DW-1:0] data_o
);

  fwd_sel_e sel;
  logic     src_nonzero;

  assign src_nonzero = (src_idx_i != {RW{1'b0}});

  // Select the youngest producer that writes this index.
  always_comb begin
    sel = FWD_REG;
    if (exmem_regwrite_i && (exmem_rd_i == src_idx_i) && src_nonzero) begin
      sel = FWD_EXMEM;
    end else if (memwb_regwrite_i && (memwb_rd_i == src_idx_i) && src_nonzero) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_REG;
    end
  end

  // Data mux driven by the select code.
  always_comb begin
    data_o = reg_data_i;
    case (sel)
      FWD_EXMEM: data_o = exmem_result_i;
      FWD_MEMWB: data_o = memwb_data_i;
      FWD_REG:   data_o = reg_data_i;
      default:   data_o = reg_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hold/bubble control, load-use detection and
// EX-stage operand forwarding feeding the ALU.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int RW  = RW_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [DW-1:0]  id_rs_data,
  input  logic [DW-1:0]  id_rt_data,
  input  logic [DW-1:0]  id_imm32,
  input  logic [RW-1:0]  id_rs,
  input  logic [RW-1:0]  id_rt,
  input  logic [RW-1:0]  id_rd,
  input  logic [OPW-1:0] id_aluop,
  input  logic           id_alusrc,
  input  logic           id_regwrite,
  input  logic           id_memread,
  input  logic           id_memwrite,
  input  logic           id_memtoreg,
  input  logic           stall,
  input  logic           flush,
  input  logic           exmem_regwrite,
  input  logic [RW-1:0]  exmem_rd,
  input  logic [DW-1:0]  exmem_result,
  input  logic           memwb_regwrite,
  input  logic [RW-1:0]  memwb_rd,
  input  logic [DW-1:0]  memwb_data,
  output logic           ld_use_stall,
  output logic           ex_valid,
  output logic [DW-1:0]  ex_a,
  output logic [DW-1:0]  ex_b,
  output logic [OPW-1:0] ex_aluop,
  output logic [DW-1:0]  ex_store_data,
  output logic [RW-1:0]  ex_rd,
  output logic           ex_regwrite,
  output logic           ex_memread,
  output logic           ex_memwrite,
  output logic           ex_memtoreg
);

  logic           valid_q,   valid_d;
  ctrl_t          ctrl_q,    ctrl_d;
  logic [OPW-1:0] aluop_q,   aluop_d;
  logic [RW-1:0]  rd_q,      rd_d;
  logic [RW-1:0]  rs_q,      rs_d;
  logic [RW-1:0]  rt_q,      rt_d;
  logic [DW-1:0]  rs_data_q, rs_data_d;
  logic [DW-1:0]  rt_data_q, rt_data_d;
  logic [DW-1:0]  imm_q,     imm_d;
  logic           alusrc_q,  alusrc_d;

  logic           hazard;
  upd_e           upd;
  ctrl_t          id_ctrl;
  logic [DW-1:0]  fwd_rs, fwd_rt;

  assign id_ctrl = '{regwrite: id_regwrite, memread: id_memread,
                     memwrite: id_memwrite, memtoreg: id_memtoreg};

  // The B operand only reads rt when the immediate is not selected.
  assign hazard = valid_q & ctrl_q.memread & (rd_q != {RW{1'b0}}) & id_valid &
                  ((rd_q == id_rs) | ((rd_q == id_rt) & ~id_alusrc));

  assign ld_use_stall = hazard;
  assign upd          = upd_select(flush, stall, hazard);

  // Next-state selection: capture, hold, or bubble.
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    aluop_d   = aluop_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    alusrc_d  = alusrc_q;
    case (upd)
      UPD_CAPTURE: begin
        valid_d   = id_valid;
        ctrl_d    = id_ctrl;
        aluop_d   = id_aluop;
        rd_d      = id_rd;
        rs_d      = id_rs;
        rt_d      = id_rt;
        rs_data_d = id_rs_data;
        rt_data_d = id_rt_data;
        imm_d     = id_imm32;
        alusrc_d  = id_alusrc;
      end
      UPD_BUBBLE: begin
        // Only the fields that could cause side effects are cleared.
        valid_d   = 1'b0;
        ctrl_d    = CTRL_NONE;
        aluop_d   = OPW'(ALUOp_NOP);
        rd_d      = {RW{1'b0}};
        rs_d      = id_rs;
        rt_d      = id_rt;
        rs_data_d = id_rs_data;
        rt_data_d = id_rt_data;
        imm_d     = id_imm32;
        alusrc_d  = id_alusrc;
      end
      UPD_HOLD: begin
        valid_d = valid_q;
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= CTRL_NONE;
      aluop_q   <= {OPW{1'b0}};
      rd_q      <= {RW{1'b0}};
      rs_q      <= {RW{1'b0}};
      rt_q      <= {RW{1'b0}};
      rs_data_q <= {DW{1'b0}};
      rt_data_q <= {DW{1'b0}};
      imm_q     <= {DW{1'b0}};
      alusrc_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      aluop_q   <= aluop_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      alusrc_q  <= alusrc_d;
    end
  end

  id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src_idx_i        (rs_q),
    .reg_data_i       (rs_data_q),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_rd_i       (exmem_rd),
    .exmem_result_i   (exmem_result),
    .memwb_regwrite_i (memwb_regwrite),
    .memwb_rd_i       (memwb_rd),
    .memwb_data_i     (memwb_data),
    .data_o           (fwd_rs)
  );

  id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src_idx_i        (rt_q),
    .reg_data_i       (rt_data_q),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_rd_i       (exmem_rd),
    .exmem_result_i   (exmem_result),
    .memwb_regwrite_i (memwb_regwrite),
    .memwb_rd_i       (memwb_rd),
    .memwb_data_i     (memwb_data),
    .data_o           (fwd_rt)
  );

  // ALU operand selection; store data always takes the forwarded rt.
  always_comb begin
    ex_a          = fwd_rs;
    ex_store_data = fwd_rt;
    if (alusrc_q) begin
      ex_b = imm_q;
    end else begin
      ex_b = fwd_rt;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_aluop    = aluop_q;
  assign ex_rd       = rd_q;
  assign ex_regwrite = ctrl_q.regwrite & valid_q;
  assign ex_memread  = ctrl_q.memread  & valid_q;
  assign ex_memwrite = ctrl_q.memwrite & valid_q;
  assign ex_memtoreg = ctrl_q.memtoreg & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios followed by random
// traffic, compared against a slot-level reference model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic [31:0] id_rs_data, id_rt_data, id_imm32, exmem_result, memwb_data;
  logic [4:0]  id_rs, id_rt, id_rd, id_aluop, exmem_rd, memwb_rd;
  logic        stall, flush, exmem_regwrite, memwb_regwrite;
  logic        ld_use_stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [4:0]  ex_aluop, ex_rd;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm32(id_imm32), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_aluop(id_aluop), .id_alusrc(id_alusrc),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .stall(stall), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ld_use_stall(ld_use_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_aluop(ex_aluop), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg)
  );

  typedef struct packed {
    logic rst, valid, alusrc, regwrite, memread, memwrite, memtoreg, stall, flush;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd, aluop;
    logic        exmem_we;  logic [4:0] exmem_rd; logic [31:0] exmem_res;
    logic        memwb_we;  logic [4:0] memwb_rd; logic [31:0] memwb_dat;
  } stim_t;

  // What the EX slot architecturally holds; data_known is cleared by bubbles.
  typedef struct packed {
    logic valid, alusrc, regwrite, memread, memwrite, memtoreg, data_known;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd, aluop;
  } slot_t;

  typedef struct packed {
    logic ld_use, valid, regw, memr, memw, m2r, data_known;
    logic [4:0]  aluop, rd;
    logic [31:0] a, b, sd;
  } exp_t;

  exp_t  sbq[$];
  slot_t m;
  bit    m_init = 1'b0;
  int    checks = 0;
  int    errors = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] regval,
                                      input stim_t s);
    if (r == 5'd0) return regval;
    if (s.exmem_we && s.exmem_rd == r) return s.exmem_res;
    if (s.memwb_we && s.memwb_rd == r) return s.memwb_dat;
    return regval;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    exp_t  e;
    slot_t nxt;
    logic  hz;
    @(negedge clk);
    rst = s.rst; id_valid = s.valid; id_rs_data = s.rs_data; id_rt_data = s.rt_data;
    id_imm32 = s.imm; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_aluop = s.aluop;
    id_alusrc = s.alusrc; id_regwrite = s.regwrite; id_memread = s.memread;
    id_memwrite = s.memwrite; id_memtoreg = s.memtoreg; stall = s.stall; flush = s.flush;
    exmem_regwrite = s.exmem_we; exmem_rd = s.exmem_rd; exmem_result = s.exmem_res;
    memwb_regwrite = s.memwb_we; memwb_rd = s.memwb_rd; memwb_data = s.memwb_dat;
    #1;
    // A load in EX is consumed by the decode slot before it can be forwarded.
    hz = m_init && m.valid && m.memread && m.rd != 5'd0 && s.valid &&
         (m.rd == s.rs || (m.rd == s.rt && !s.alusrc));
    if (m_init) begin
      e.ld_use = hz;
      e.valid = m.valid;
      e.regw = m.valid & m.regwrite;
      e.memr = m.valid & m.memread;
      e.memw = m.valid & m.memwrite;
      e.m2r  = m.valid & m.memtoreg;
      e.aluop = m.aluop;
      e.rd = m.rd;
      e.data_known = m.data_known;
      e.a  = fwd(m.rs, m.rs_data, s);
      e.sd = fwd(m.rt, m.rt_data, s);
      e.b  = m.alusrc ? m.imm : e.sd;
      sbq.push_back(e);
    end
    nxt = '{valid: s.valid, alusrc: s.alusrc, regwrite: s.regwrite, memread: s.memread,
            memwrite: s.memwrite, memtoreg: s.memtoreg, data_known: 1'b1,
            rs_data: s.rs_data, rt_data: s.rt_data, imm: s.imm,
            rs: s.rs, rt: s.rt, rd: s.rd, aluop: s.aluop};
    if (s.rst) begin
      m = '0;
      m.data_known = 1'b1;
      m_init = 1'b1;
    end else if (!m_init) begin
      m = '0;
    end else if (s.flush || (!s.stall && hz)) begin
      m = '0;
    end else if (!s.stall) begin
      m = nxt;
    end
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s.rst = ($urandom_range(0, 99) < 2);
    s.valid = ($urandom_range(0, 9) != 0);
    s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom;
    s.rs = 5'($urandom_range(0, 4)); s.rt = 5'($urandom_range(0, 4));
    s.rd = 5'($urandom_range(0, 4)); s.aluop = 5'($urandom_range(0, 4));
    s.alusrc = ($urandom_range(0, 9) < 3);
    s.regwrite = $urandom_range(0, 1);
    s.memread = ($urandom_range(0, 9) < 4);
    s.memwrite = $urandom_range(0, 1);
    s.memtoreg = $urandom_range(0, 1);
    s.stall = ($urandom_range(0, 9) < 2);
    s.flush = ($urandom_range(0, 9) < 1);
    s.exmem_we = $urandom_range(0, 1); s.exmem_rd = 5'($urandom_range(0, 4));
    s.exmem_res = $urandom;
    s.memwb_we = $urandom_range(0, 1); s.memwb_rd = 5'($urandom_range(0, 4));
    s.memwb_dat = $urandom;
    return s;
  endfunction

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("ld_use_stall", {31'd0, ld_use_stall}, {31'd0, e.ld_use});
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
        chk("ex_aluop", {27'd0, ex_aluop}, {27'd0, e.aluop});
        chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
        chk("ex_ctrl", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
            {28'd0, e.regw, e.memr, e.memw, e.m2r});
        if (e.data_known) begin
          chk("ex_a", ex_a, e.a);
          chk("ex_b", ex_b, e.b);
          chk("ex_store_data", ex_store_data, e.sd);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    guard;
    s = idle(); s.rst = 1'b1;
    apply(s);
    apply(s);
    // Reset then capture
    s = idle(); s.valid = 1'b1; s.rs = 5'd1; s.rt = 5'd2; s.rs_data = 32'd5;
    s.rt_data = 32'd7; s.aluop = ALUOp_ADDU; s.rd = 5'd3; s.regwrite = 1'b1;
    apply(s);
    // Immediate select
    s = idle(); s.valid = 1'b1; s.rs = 5'd1; s.rt = 5'd2; s.alusrc = 1'b1;
    s.imm = 32'hFFFF_FFFC; s.rt_data = 32'd9; s.rd = 5'd5; s.regwrite = 1'b1;
    apply(s);
    // Forward priority on rs=4, held with stall while sources change
    s = idle(); s.valid = 1'b1; s.rs = 5'd4; s.rs_data = 32'h99; s.aluop = ALUOp_OR;
    apply(s);
    s = idle(); s.stall = 1'b1; s.exmem_we = 1'b1; s.exmem_rd = 5'd4;
    s.exmem_res = 32'h11; s.memwb_we = 1'b1; s.memwb_rd = 5'd4; s.memwb_dat = 32'h22;
    apply(s);
    s.exmem_we = 1'b0;
    apply(s);
    s = idle(); s.valid = 1'b1; s.rs = 5'd0; s.rs_data = 32'h55;
    apply(s);
    s = idle(); s.stall = 1'b1; s.exmem_we = 1'b1; s.exmem_rd = 5'd0;
    s.exmem_res = 32'h11; s.memwb_we = 1'b1; s.memwb_rd = 5'd0; s.memwb_dat = 32'h22;
    apply(s);
    apply(s);
    // Load-use bubble
    s = idle(); s.valid = 1'b1; s.memread = 1'b1; s.regwrite = 1'b1; s.memtoreg = 1'b1;
    s.rd = 5'd8; s.rs = 5'd2;
    apply(s);
    s = idle(); s.valid = 1'b1; s.rs = 5'd8; s.rd = 5'd9; s.regwrite = 1'b1;
    s.aluop = ALUOp_ADD;
    apply(s);
    apply(idle());
    apply(idle());
    // Stall for three cycles with changing decode inputs, then stall+flush
    s = idle(); s.valid = 1'b1; s.rs = 5'd3; s.rt = 5'd1; s.rd = 5'd6; s.regwrite = 1'b1;
    s.memwrite = 1'b1; s.aluop = ALUOp_SUBU; s.rs_data = 32'hA5A5_0001; s.rt_data = 32'h3C;
    apply(s);
    for (int i = 0; i < 3; i++) begin
      s = rnd(); s.rst = 1'b0; s.flush = 1'b0; s.stall = 1'b1;
      apply(s);
    end
    s = rnd(); s.rst = 1'b0; s.stall = 1'b1; s.flush = 1'b1;
    apply(s);
    apply(idle());
    // Stall while a load-use hazard is pending: EX holds the load
    s = idle(); s.valid = 1'b1; s.memread = 1'b1; s.regwrite = 1'b1; s.rd = 5'd8;
    apply(s);
    s = idle(); s.valid = 1'b1; s.rt = 5'd8; s.rd = 5'd2; s.stall = 1'b1;
    apply(s);
    s.stall = 1'b0;
    apply(s);
    apply(idle());
    // Reset mid-operation together with stall
    s = idle(); s.valid = 1'b1; s.regwrite = 1'b1; s.memwrite = 1'b1; s.memtoreg = 1'b1;
    s.rd = 5'd7; s.aluop = ALUOp_ADD; s.rs = 5'd1; s.rs_data = 32'h1234;
    apply(s);
    s = idle(); s.rst = 1'b1; s.stall = 1'b1; s.flush = 1'b1;
    apply(s);
    apply(idle());
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      apply(rnd());
    end
    apply(idle());
    guard = 0;
    while (sbq.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #3;
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
